// File: rtl/mtimer_pkg.sv
// Shared constants for the machine-mode timer: register word offsets, ctrl field
// positions and reset values.
package mtimer_pkg;

  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] CTRL        = 3'd4;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;

  localparam logic [63:0] MTIME_RESET     = 64'h0;
  localparam logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] RDATA_RESET     = 32'h0;

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for mtime: counts 0..div while enabled and pulses tick on the
// cycle the count equals div (div = 0 ticks every cycle).
module mtimer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mtimer.sv
// Machine-mode timer: 64-bit prescaled mtime, 64-bit mtimecmp, active-low level
// interrupt, single-beat slave. MTIMER_SNAPSHOT_EN adds a tear-free mtime_hi shadow.
module mtimer
  import mtimer_pkg::*;
#(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = MTIMECMP_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        ti
);

  logic                  access, wr, rd;
  logic                  tick, ctrl_wr;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ack_q, ti_q;
  logic [31:0]           ctrl_rd, rd_val;

  assign access  = ~cs;
  assign wr      = access & ~we;
  assign rd      = access & we;
  assign ctrl_wr = wr && (addr == CTRL);

  mtimer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en_q),
    .div  (div_q),
    .clr  (ctrl_wr),
    .tick (tick)
  );

`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] shadow_q, shadow_d;
`endif

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN_BIT] = en_q;
    ctrl_rd[CTRL_DIV_LSB +: PRESCALE_W] = div_q;
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      MTIME_LO:    rd_val = mtime_q[31:0];
`ifdef MTIMER_SNAPSHOT_EN
      MTIME_HI:    rd_val = shadow_q;
`else
      MTIME_HI:    rd_val = mtime_q[63:32];
`endif
      MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
      MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
      CTRL:        rd_val = ctrl_rd;
      default:     rd_val = '0;
    endcase
  end

  // A software write to either mtime half wins over the prescaler tick.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    div_d      = div_q;
    if (wr && addr == MTIME_LO) begin
      mtime_d[31:0] = wdata;
    end else if (wr && addr == MTIME_HI) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wr && addr == MTIMECMP_LO) mtimecmp_d[31:0]  = wdata;
    if (wr && addr == MTIMECMP_HI) mtimecmp_d[63:32] = wdata;
    if (ctrl_wr) begin
      en_d  = wdata[CTRL_EN_BIT];
      div_d = wdata[CTRL_DIV_LSB +: PRESCALE_W];
    end
    rdata_d = rd ? rd_val : rdata_q;
  end

`ifdef MTIMER_SNAPSHOT_EN
  always_comb begin
    shadow_d = shadow_q;
    if (rd && addr == MTIME_LO) shadow_d = mtime_q[63:32];
    if (wr && (addr == MTIME_LO || addr == MTIME_HI)) shadow_d = mtime_d[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= MTIME_RESET;
      mtimecmp_q <= CMP_RESET;
      en_q       <= 1'b0;
      div_q      <= '0;
      rdata_q    <= RDATA_RESET;
      ack_q      <= 1'b0;
      ti_q       <= 1'b1;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      div_q      <= div_d;
      rdata_q    <= rdata_d;
      ack_q      <= access;
      ti_q       <= ~(mtime_q >= mtimecmp_q);
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign ti    = ti_q;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: directed scenarios plus random accesses, all
// checked against a cycle-level behavioural model of the timer.
module tb_mtimer;

  logic        clk = 1'b0;
  logic        rst, cs, we;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ack, ti;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mtimer dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .ti(ti)
  );

  logic [63:0] m_time, m_cmp;
  logic        m_en, m_ti, m_ack;
  int          m_div, m_pc;
  logic [31:0] m_rdata;
`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0] m_shadow;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_time = 64'h0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en = 1'b0; m_div = 0; m_pc = 0;
    m_ti = 1'b1; m_ack = 1'b0; m_rdata = 32'h0;
`ifdef MTIMER_SNAPSHOT_EN
    m_shadow = 32'h0;
`endif
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] c;
    c = 32'h0;
    c[0] = m_en;
    c[15:8] = m_div[7:0];
    case (a)
      3'd0: return m_time[31:0];
`ifdef MTIMER_SNAPSHOT_EN
      3'd1: return m_shadow;
`else
      3'd1: return m_time[63:32];
`endif
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return c;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the timer as software sees it, from pre-edge state.
  task automatic model_edge(input logic c, input logic w, input logic [2:0] a, input logic [31:0] d);
    logic tick, acc, mwrite;
    logic [31:0] rv;
    acc    = !c;
    tick   = m_en && (m_pc == m_div);
    rv     = m_read(a);
    m_ti   = !(m_time >= m_cmp);
    m_ack  = acc;
    if (m_en) m_pc = tick ? 0 : m_pc + 1;
    mwrite = acc && !w && (a == 3'd0 || a == 3'd1);
    if (acc && w) begin
      m_rdata = rv;
`ifdef MTIMER_SNAPSHOT_EN
      if (a == 3'd0) m_shadow = m_time[63:32];
`endif
    end
    if (acc && !w) begin
      case (a)
        3'd0: m_time[31:0]  = d;
        3'd1: m_time[63:32] = d;
        3'd2: m_cmp[31:0]   = d;
        3'd3: m_cmp[63:32]  = d;
        3'd4: begin m_en = d[0]; m_div = int'(d[15:8]); m_pc = 0; end
        default: ;
      endcase
`ifdef MTIMER_SNAPSHOT_EN
      if (mwrite) m_shadow = m_time[63:32];
`endif
    end
    if (!mwrite && tick) m_time = m_time + 64'd1;
  endtask

  task automatic cyc(input logic c, input logic w, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = c; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge(c, w, a, d);
    #1;
    check("ack", {63'h0, ack}, {63'h0, m_ack});
    check("ti", {63'h0, ti}, {63'h0, m_ti});
    check("rdata", {32'h0, rdata}, {32'h0, m_rdata});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 3'd0, 32'h0);
  endtask

  initial begin
    logic [31:0] last, d;
    int last_k, n;
    logic c, w;
    logic [2:0] a;

    rst = 1'b1; cs = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h0;
    model_reset();
    #23 rst = 1'b0;
    check("reset_ti", {63'h0, ti}, 64'h1);
    check("reset_ack", {63'h0, ack}, 64'h0);
    check("reset_rdata", {32'h0, rdata}, 64'h0);
    rd(3'd2); check("cmp_lo_reset", {32'h0, rdata}, 64'hFFFF_FFFF);
    rd(3'd3); check("cmp_hi_reset", {32'h0, rdata}, 64'hFFFF_FFFF);
    rd(3'd0); check("mtime_lo_reset", {32'h0, rdata}, 64'h0);
    idle(1);
    check("ack_one_cycle", {63'h0, ack}, 64'h0);

    // Prescaled counting, DIV = 3: a tick every 4 cycles.
    wr(3'd4, 32'h0000_0301);
    last = 32'h0; last_k = -1;
    for (int k = 1; k <= 40; k++) begin
      rd(3'd0);
      if (rdata != last) begin
        if (last_k >= 0) check("tick_spacing", k - last_k, 4);
        last = rdata; last_k = k;
      end
    end
    check("rate_in_range", {63'h0, (rdata >= 32'd9 && rdata <= 32'd11)}, 64'h1);
    rd(3'd4); check("ctrl_readback", {32'h0, rdata}, 64'h0000_0301);
    wr(3'd4, 32'h0);

    // Carry from lo into hi, then full 64-bit wrap.
    wr(3'd0, 32'hFFFF_FFFE); wr(3'd1, 32'h0);
    wr(3'd4, 32'h1); idle(1); wr(3'd4, 32'h0);
    rd(3'd0); check("carry_lo", {32'h0, rdata}, 64'h0);
    rd(3'd1); check("carry_hi", {32'h0, rdata}, 64'h1);
    wr(3'd0, 32'hFFFF_FFFF); wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd4, 32'h1); wr(3'd4, 32'h0);
    rd(3'd0); check("wrap_lo", {32'h0, rdata}, 64'h0);
    rd(3'd1); check("wrap_hi", {32'h0, rdata}, 64'h0);

    // Interrupt assert/deassert latency.
    wr(3'd0, 32'd100); wr(3'd1, 32'h0);
    wr(3'd3, 32'h0); wr(3'd2, 32'd105);
    wr(3'd4, 32'h1);
    n = 0;
    while (n < 20 && ti !== 1'b0) begin
      idle(1);
      n++;
    end
    check("ti_fall_latency", n, 6);
    wr(3'd2, 32'd200);
    check("ti_still_low", {63'h0, ti}, 64'h0);
    idle(1);
    check("ti_release", {63'h0, ti}, 64'h1);
    wr(3'd4, 32'h0);

    // Write to mtime_lo on a tick cycle: no increment that cycle.
    wr(3'd4, 32'h1);
    wr(3'd0, 32'h1234);
    rd(3'd0); check("collision_lo", {32'h0, rdata}, 64'h1234);
    wr(3'd4, 32'h0);

    // mtime_hi read three cycles after a lo read across a carry.
    wr(3'd0, 32'hFFFF_FFFF); wr(3'd1, 32'h1);
    wr(3'd4, 32'h1);
    rd(3'd0); check("snap_lo", {32'h0, rdata}, 64'hFFFF_FFFF);
    idle(2);
    rd(3'd1);
`ifdef MTIMER_SNAPSHOT_EN
    check("snap_hi", {32'h0, rdata}, 64'h1);
`else
    check("snap_hi", {32'h0, rdata}, 64'h2);
`endif
    wr(3'd4, 32'h0);
    rd(3'd6); check("reserved_read", {32'h0, rdata}, 64'h0);

    // Random accesses against the model.
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 3) == 0);
      w = $urandom_range(0, 1) == 1;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      case (a)
        3'd0: if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        3'd1: d = 32'($urandom_range(0, 2));
        3'd2: d = m_time[31:0] + 32'($urandom_range(0, 24)) - 32'd8;
        3'd3: d = m_time[63:32] + 32'($urandom_range(0, 1));
        3'd4: d = d & 32'hFFFF_03FF;
        default: ;
      endcase
      cyc(c, w, a, d);
    end
    idle(2);

    // Reset in the middle of an access: no ack, registers back to reset.
    @(negedge clk);
    cs = 1'b0; we = 1'b1; addr = 3'd2; wdata = 32'h0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ack", {63'h0, ack}, 64'h0);
    check("abort_ti", {63'h0, ti}, 64'h1);
    check("abort_rdata", {32'h0, rdata}, 64'h0);
    @(negedge clk);
    cs = 1'b1; rst = 1'b0;
    model_reset();
    rd(3'd3); check("post_reset_cmp_hi", {32'h0, rdata}, 64'hFFFF_FFFF);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Machine-mode timer peripheral; drives the active-low timer interrupt `ti` consumed by the CSR unit.
- Holds a 64-bit free-running `mtime` (with prescaler) and a 64-bit `mtimecmp`, both memory-mapped.
- Raises `ti` while `mtime >= mtimecmp`.
- Sits on the core's load/store path as a simple single-beat slave.

Parameters:
- PRESCALE_W, 8, width of prescale divisor field and counter.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of `mtimecmp` (no interrupt after reset).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active high
- cs  in  1  access select, ACTIVE LOW
- we  in  1  write strobe, ACTIVE LOW (high = read); sampled only while `cs` is low
- addr  in  3  word offset: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi, 4 ctrl; 5-7 reserved
- wdata  in  32  write data
- rdata  out  32  registered read data
- ack  out  1  one-cycle completion pulse, active high
- ti  out  1  timer interrupt, ACTIVE LOW

Behaviour:
- Reset:
  - `mtime` = 0; `mtimecmp` = CMP_RESET.
  - ctrl = 0: counting disabled, divisor 0.
  - Prescale counter = 0; `rdata` = 0; `ack` = 0; `ti` = 1 (inactive).
  - Reset mid-access aborts the access with no `ack`.
- ctrl register:
  - bit0 EN.
  - bits[8+PRESCALE_W-1:8] DIV.
  - Other bits read 0.
- Prescaler (EN = 1):
  - Counts 0..DIV, then wraps to 0.
  - `mtime` increments on the cycle the counter equals DIV, so DIV = 0 means every cycle.
  - EN = 0 holds both the counter and `mtime`.
  - A write to ctrl clears the prescale counter.
- Counter:
  - 64-bit increment with carry from lo into hi.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Access:
  - `cs` low at an edge performs the access that edge.
  - `ack` is high the following cycle.
  - Back-to-back accesses are legal, one per cycle.
  - Reads: `rdata` updates with `ack`; otherwise it holds its last value.
  - Reserved addresses read 0; writes to them are ignored but still acked.
- Write/increment collision:
  - A write to mtime_lo or mtime_hi in a tick cycle takes priority; there is no increment that cycle.
  - The written half takes `wdata`; the other half holds.
- Interrupt:
  - `ti` is registered: `ti <= ~(mtime >= mtimecmp)`, using current register values (unsigned 64-bit compare).
  - `ti` therefore falls one cycle after the condition first holds.
  - `ti` is level; it stays low until `mtimecmp` is raised above `mtime` or `mtime` wraps.
  - Compare is independent of EN.
- Writing mtimecmp is half-at-a-time. Software writes hi = all-ones first to avoid a spurious `ti`; the hardware does not protect against this.

Optional Feature:
- Macro: MTIMER_SNAPSHOT_EN.
- Defined:
  - A read of mtime_lo also captures the current `mtime[63:32]` into a 32-bit shadow register.
  - The next read of mtime_hi returns the shadow, giving a tear-free 64-bit read.
  - Any write to `mtime` also reloads the shadow with the new hi value.
  - Shadow resets to 0.
- Undefined:
  - mtime_hi reads return live `mtime[63:32]`.
  - No shadow register is built.

Decomposition:
- Package `mtimer_pkg`:
  - Word offsets MTIME_LO/MTIME_HI/MTIMECMP_LO/MTIMECMP_HI/CTRL.
  - CTRL_EN_BIT and CTRL_DIV_LSB constants.
  - Reset value constants.
- Sub-module `mtimer_prescaler`:
  - Inputs: clk, rst, en, div, clr.
  - Output: one-cycle tick.

Test Plan:
- Reset → `ti` = 1, `rdata` = 0, `ack` = 0; read addr 2/3 → 32'hFFFFFFFF each; read addr 0 → 0.
- Write ctrl = 32'h0000_0301 (EN, DIV = 3); run 40 cycles → `mtime` = 10 (±1 at start boundary); ticks spaced exactly 4 cycles.
- Write mtime_lo = 32'hFFFF_FFFE, mtime_hi = 0, DIV = 0, EN → after 2 ticks mtime_lo = 0, mtime_hi = 1; separately, mtime = all-ones wraps to 0.
- mtime = 100, set mtimecmp_hi = 0 then mtimecmp_lo = 105 → `ti` falls exactly one cycle after `mtime` reaches 105; write mtimecmp_lo = 200 → `ti` returns high one cycle after the compare clears.
- Write mtime_lo = 32'h1234 in a tick cycle → reads back 32'h1234 (no +1 that cycle).
- MTIMER_SNAPSHOT_EN: mtime = 32'h0000_0001_FFFF_FFFF, DIV = 0; read lo, then hi 3 cycles later → hi returns 1 (live would be 2); without the macro → 2.
